// File: rtl/iq_shifter_agc.sv
// iq_shifter_agc: selects an OUT_WIDTH window from wide I/Q samples with clamping, saturation
// and windowed automatic gain. Define IQ_SHIFTER_ROUNDING_EN for round-half-up (else truncation).
module iq_shifter_agc #(
  parameter int IN_WIDTH      = 88,
  parameter int OUT_WIDTH     = 32,
  parameter int DIST_WIDTH    = 8,
  parameter int PEAK_WINDOW   = 4096,
  parameter int HEADROOM_BITS = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic signed [IN_WIDTH-1:0]   in_I,
  input  logic signed [IN_WIDTH-1:0]   in_Q,
  input  logic        [DIST_WIDTH-1:0] distance_manual,
  input  logic                         auto_en,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_I,
  output logic signed [OUT_WIDTH-1:0]  out_Q,
  output logic                         sat_I,
  output logic                         sat_Q,
  output logic        [DIST_WIDTH-1:0] distance_cur
);

  localparam int CNT_W = $clog2(PEAK_WINDOW);
  localparam int EXT_W = IN_WIDTH + 1;
  localparam logic [DIST_WIDTH-1:0] D_MIN = DIST_WIDTH'(OUT_WIDTH);
  localparam logic [DIST_WIDTH-1:0] D_MAX = DIST_WIDTH'(IN_WIDTH);
  localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {ST_MANUAL, ST_AUTO} state_t;

  state_t                r_state;
  logic [DIST_WIDTH-1:0] r_dist;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_hit_hi;
  logic                  r_hit_lo;
  logic                  r_s1_valid;
  logic                  r_out_valid;

  logic [DIST_WIDTH-1:0] w_dist_clamped;
  logic [DIST_WIDTH-1:0] w_shift;
  logic [DIST_WIDTH-1:0] w_k_hi;
  logic [DIST_WIDTH-1:0] w_k_lo;
  logic [1:0]            w_ovf;
  logic [1:0]            w_hi;
  logic [1:0]            w_lo;
  logic                  w_win_hi;
  logic                  w_win_lo;

  always_comb begin
    w_dist_clamped = distance_manual;
    if (distance_manual < D_MIN) begin
      w_dist_clamped = D_MIN;
    end else if (distance_manual > D_MAX) begin
      w_dist_clamped = D_MAX;
    end
  end

  assign w_shift      = r_dist - D_MIN;
  assign w_k_hi       = r_dist - DIST_WIDTH'(HEADROOM_BITS + 1);
  assign w_k_lo       = r_dist - DIST_WIDTH'(HEADROOM_BITS + 2);
  assign distance_cur = r_dist;
  assign out_valid    = r_out_valid;

  // Window flags include the sample being accepted this cycle.
  assign w_win_hi = r_hit_hi | (|w_hi) | (|w_ovf);
  assign w_win_lo = r_hit_lo | (|w_lo);

  // Channel 0 is I, channel 1 is Q; both share the valid pipeline.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [IN_WIDTH-1:0] w_in;
    logic signed [EXT_W-1:0]    w_ext;
    logic signed [EXT_W-1:0]    w_shifted;
    logic [IN_WIDTH-1:0]        w_mag;
    logic [OUT_WIDTH-1:0]       r_s1_data;
    logic                       r_s1_ovf;
    logic                       r_s1_neg;
    logic [OUT_WIDTH-1:0]       r_out;
    logic                       r_sat;

    assign w_in = (gi == 0) ? in_I : in_Q;

`ifdef IQ_SHIFTER_ROUNDING_EN
    assign w_ext = $signed({w_in[IN_WIDTH-1], w_in} +
                           ((w_shift == '0) ? '0 : (EXT_W'(1) << (w_shift - DIST_WIDTH'(1)))));
`else
    assign w_ext = $signed({w_in[IN_WIDTH-1], w_in});
`endif

    assign w_shifted = w_ext >>> w_shift;
    assign w_ovf[gi] = ~((&w_shifted[EXT_W-1:OUT_WIDTH-1]) | ~(|w_shifted[EXT_W-1:OUT_WIDTH-1]));

    // ~x for negative x makes the threshold test strict (x < -T).
    assign w_mag    = w_in[IN_WIDTH-1] ? ~w_in : w_in;
    assign w_hi[gi] = |(w_mag >> w_k_hi);
    assign w_lo[gi] = |(w_mag >> w_k_lo);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1_data <= '0;
        r_s1_ovf  <= 1'b0;
        r_s1_neg  <= 1'b0;
      end else if (in_valid) begin
        r_s1_data <= w_shifted[OUT_WIDTH-1:0];
        r_s1_ovf  <= w_ovf[gi];
        r_s1_neg  <= w_shifted[EXT_W-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out <= '0;
        r_sat <= 1'b0;
      end else if (r_s1_valid) begin
        r_out <= r_s1_ovf ? (r_s1_neg ? SAT_NEG : SAT_POS) : r_s1_data;
        r_sat <= r_s1_ovf;
      end else begin
        r_sat <= 1'b0;
      end
    end

    if (gi == 0) begin : g_i
      assign out_I = r_out;
      assign sat_I = r_sat;
    end else begin : g_q
      assign out_Q = r_out;
      assign sat_Q = r_sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid  <= in_valid;
      r_out_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_MANUAL;
      r_dist   <= D_MAX;
      r_cnt    <= '0;
      r_hit_hi <= 1'b0;
      r_hit_lo <= 1'b0;
    end else begin
      case (r_state)
        ST_MANUAL: begin
          r_cnt    <= '0;
          r_hit_hi <= 1'b0;
          r_hit_lo <= 1'b0;
          if (auto_en) begin
            r_state <= ST_AUTO;
          end else begin
            r_dist <= w_dist_clamped;
          end
        end
        ST_AUTO: begin
          if (!auto_en) begin
            r_state  <= ST_MANUAL;
            r_dist   <= w_dist_clamped;
            r_cnt    <= '0;
            r_hit_hi <= 1'b0;
            r_hit_lo <= 1'b0;
          end else if (in_valid) begin
            if (r_cnt == CNT_W'(PEAK_WINDOW - 1)) begin
              r_cnt    <= '0;
              r_hit_hi <= 1'b0;
              r_hit_lo <= 1'b0;
              if (w_win_hi) begin
                if (r_dist < D_MAX) r_dist <= r_dist + DIST_WIDTH'(1);
              end else if (!w_win_lo && (r_dist > D_MIN)) begin
                r_dist <= r_dist - DIST_WIDTH'(1);
              end
            end else begin
              r_cnt    <= r_cnt + CNT_W'(1);
              r_hit_hi <= w_win_hi;
              r_hit_lo <= w_win_lo;
            end
          end
        end
        default: r_state <= ST_MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_shifter_agc.sv
// tb_iq_shifter_agc: scoreboard bench for iq_shifter_agc (manual, clamp, saturation, auto gain, reset).
module tb_iq_shifter_agc;
  localparam int IW = 88;
  localparam int OW = 32;
  localparam int DW = 8;
  localparam int PW = 16;
  localparam int HB = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic auto_en = 1'b0;
  logic signed [IW-1:0] in_I = '0;
  logic signed [IW-1:0] in_Q = '0;
  logic [DW-1:0] distance_manual = 8'd88;
  logic out_valid, sat_I, sat_Q;
  logic signed [OW-1:0] out_I, out_Q;
  logic [DW-1:0] distance_cur;

  typedef struct {
    logic [OW-1:0] i;
    logic [OW-1:0] q;
    logic si;
    logic sq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int txn = 0;
  int run_len = 0;
  int max_run = 0;
  int model_d = 88;
  int m_cnt = 0;
  bit m_hi = 0, m_lo = 0, m_auto = 0;
  logic signed [IW-1:0] p40, p42;

  iq_shifter_agc #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DIST_WIDTH(DW), .PEAK_WINDOW(PW), .HEADROOM_BITS(HB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_I(in_I), .in_Q(in_Q),
    .distance_manual(distance_manual), .auto_en(auto_en), .out_valid(out_valid),
    .out_I(out_I), .out_Q(out_Q), .sat_I(sat_I), .sat_Q(sat_Q), .distance_cur(distance_cur)
  );

  always #5 clk = ~clk;

  function automatic int clampd(input int v);
    if (v < OW) return OW;
    if (v > IW) return IW;
    return v;
  endfunction

  function automatic void model_ch(input logic signed [IW-1:0] x, input int d,
                                   output logic [OW-1:0] y, output logic sat);
    logic signed [127:0] v;
    int s;
    s = d - OW;
    v = x;
`ifdef IQ_SHIFTER_ROUNDING_EN
    if (s > 0) v = v + (128'sd1 <<< (s - 1));
`endif
    v = v >>> s;
    if (v > 128'sd2147483647) begin
      y = 32'h7FFFFFFF; sat = 1'b1;
    end else if (v < -128'sd2147483648) begin
      y = 32'h80000000; sat = 1'b1;
    end else begin
      y = v[OW-1:0]; sat = 1'b0;
    end
  endfunction

  function automatic bit over(input logic signed [IW-1:0] x, input int k);
    logic signed [127:0] v, t;
    v = x;
    t = 128'sd1 <<< k;
    return (v >= t) || (v < -t);
  endfunction

  function automatic logic signed [IW-1:0] rand88();
    logic [95:0] r;
    logic signed [IW-1:0] x;
    r = {$urandom(), $urandom(), $urandom()};
    x = r[IW-1:0];
    x = x >>> $urandom_range(IW - 1, 0);
    return x;
  endfunction

  task automatic agc_step(input logic signed [IW-1:0] xi, input logic signed [IW-1:0] xq, input bit sat);
    bit hi, lo;
    hi = m_hi || sat || over(xi, model_d - 1 - HB) || over(xq, model_d - 1 - HB);
    lo = m_lo || over(xi, model_d - 2 - HB) || over(xq, model_d - 2 - HB);
    m_cnt++;
    if (m_cnt == PW) begin
      if (hi) begin
        if (model_d < IW) model_d++;
      end else if (!lo && model_d > OW) begin
        model_d--;
      end
      m_cnt = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_hi = hi; m_lo = lo;
    end
  endtask

  task automatic send_exp(input logic signed [IW-1:0] xi, input logic signed [IW-1:0] xq, input exp_t e);
    @(posedge clk); #1;
    in_valid = 1'b1; in_I = xi; in_Q = xq;
    sb_q.push_back(e);
    if (m_auto) agc_step(xi, xq, e.si | e.sq);
  endtask

  task automatic send(input logic signed [IW-1:0] xi, input logic signed [IW-1:0] xq);
    exp_t e;
    model_ch(xi, model_d, e.i, e.si);
    model_ch(xq, model_d, e.q, e.sq);
    send_exp(xi, xq, e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_manual(input int v);
    @(posedge clk); #1;
    distance_manual = DW'(v);
    @(posedge clk); #1;
    model_d = clampd(v);
  endtask

  // Scoreboard monitor: compares every output strobe, and checks sat_* is low when idle.
  always @(negedge clk) begin
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: out_I=%h out_Q=%h, no sample outstanding", out_I, out_Q);
      end else begin
        mon_e = sb_q.pop_front();
        txn++;
        $display("txn %0d: out_I=%h out_Q=%h sat=%b%b d=%0d", txn, out_I, out_Q, sat_I, sat_Q, distance_cur);
        if (out_I !== mon_e.i || out_Q !== mon_e.q || sat_I !== mon_e.si || sat_Q !== mon_e.sq) begin
          bad++;
          $display("FAIL data txn %0d: got I=%h Q=%h sat=%b%b, expected I=%h Q=%h sat=%b%b",
                   txn, out_I, out_Q, sat_I, sat_Q, mon_e.i, mon_e.q, mon_e.si, mon_e.sq);
        end
      end
    end else begin
      run_len = 0;
      total++;
      if (sat_I !== 1'b0 || sat_Q !== 1'b0) begin
        bad++;
        $display("FAIL idle_sat: sat=%b%b while out_valid=0, expected 00", sat_I, sat_Q);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (out_I !== '0) begin bad++; $display("FAIL reset_out_I: got %h expected 0", out_I); end
    total++; if (out_Q !== '0) begin bad++; $display("FAIL reset_out_Q: got %h expected 0", out_Q); end
    total++; if ({sat_I, sat_Q} !== 2'b00) begin bad++; $display("FAIL reset_sat: got %b%b expected 00", sat_I, sat_Q); end
    total++; if (distance_cur !== 8'd88) begin bad++; $display("FAIL reset_distance: got %0d expected 88", distance_cur); end
    @(negedge clk);
    reset_n = 1'b1;
    model_d = 88;
  endtask

  task automatic test_manual();
    exp_t e;
    set_manual(40);
`ifdef IQ_SHIFTER_ROUNDING_EN
    e.i = 32'h12345679;
`else
    e.i = 32'h12345678;
`endif
    e.q = 32'hFFFFFFFF; e.si = 1'b0; e.sq = 1'b0;
    send_exp(88'sh12345678AB, -88'sh100, e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: out_valid=%b one cycle after in_valid, expected 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL latency: out_valid=%b two cycles after in_valid, expected 1", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL strobe_width: out_valid=%b three cycles after in_valid, expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    exp_t e;
    set_manual(32);
    e.i = 32'h7FFFFFFF; e.q = 32'h80000000; e.si = 1'b1; e.sq = 1'b1;
    send_exp(p40, -p40, e);
    e.i = 32'h00000005; e.q = 32'h00000000; e.si = 1'b0; e.sq = 1'b0;
    send_exp(88'sd5, 88'sd0, e);
    idle();
    repeat (4) @(posedge clk);
  endtask

  task automatic test_clamp();
    set_manual(10);
    total++; if (distance_cur !== 8'd32) begin bad++; $display("FAIL clamp_low: distance_cur=%0d expected 32", distance_cur); end
    set_manual(200);
    total++; if (distance_cur !== 8'd88) begin bad++; $display("FAIL clamp_high: distance_cur=%0d expected 88", distance_cur); end
    set_manual(60);
    max_run = 0;
    for (int n = 0; n < 8; n++) send(rand88(), rand88());
    idle();
    repeat (5) @(posedge clk);
    total++; if (max_run !== 8) begin bad++; $display("FAIL back_to_back_run: longest out_valid run=%0d expected 8", max_run); end
  endtask

  task automatic test_auto();
    int prev_d;
    set_manual(88);
    @(posedge clk); #1;
    auto_en = 1'b1; m_auto = 1; m_cnt = 0; m_hi = 0; m_lo = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 704 + 32; n++) begin
      prev_d = model_d;
      send(p40, '0);
      total++;
      if (distance_cur !== DW'(prev_d)) begin
        bad++; $display("FAIL auto_track sample %0d: distance_cur=%0d expected %0d", n, distance_cur, prev_d);
      end
      if (n == 703) begin
        @(posedge clk); #1;
        total++; if (distance_cur !== 8'd44) begin bad++; $display("FAIL auto_settle: distance_cur=%0d expected 44", distance_cur); end
        in_valid = 1'b0;
      end
    end
    idle();
    total++; if (distance_cur !== 8'd44) begin bad++; $display("FAIL auto_hold: distance_cur=%0d expected 44", distance_cur); end
    for (int n = 0; n < PW; n++) send(p42, '0);
    idle();
    total++; if (distance_cur !== 8'd45) begin bad++; $display("FAIL auto_step_up: distance_cur=%0d expected 45", distance_cur); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_auto_exit();
    for (int n = 0; n < 7; n++) send(p42, '0);
    idle();
    @(posedge clk); #1;
    distance_manual = 8'd50; auto_en = 1'b0;
    m_auto = 0; m_cnt = 0; m_hi = 0; m_lo = 0;
    @(posedge clk); #1;
    model_d = 50;
    total++; if (distance_cur !== 8'd50) begin bad++; $display("FAIL auto_exit: distance_cur=%0d expected 50", distance_cur); end
    auto_en = 1'b1; m_auto = 1;
    @(posedge clk); #1;
    for (int n = 0; n < PW - 1; n++) send(p42, '0);
    idle();
    total++; if (distance_cur !== 8'd50) begin bad++; $display("FAIL auto_restart_early: distance_cur=%0d expected 50", distance_cur); end
    send(p42, '0);
    idle();
    total++; if (distance_cur !== 8'd49) begin bad++; $display("FAIL auto_restart_step: distance_cur=%0d expected 49", distance_cur); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(posedge clk); #1;
    auto_en = 1'b0; m_auto = 0;
    set_manual(50);
    send(88'sh123456789ABCDEF, -88'sh3456789ABCD);
    send(88'sh0FEDCBA98765, 88'sh77);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: out_valid=%b expected 0", out_valid); end
    total++; if (out_I !== '0 || out_Q !== '0) begin bad++; $display("FAIL midreset_data: out_I=%h out_Q=%h expected 0", out_I, out_Q); end
    total++; if (distance_cur !== 8'd88) begin bad++; $display("FAIL midreset_distance: distance_cur=%0d expected 88", distance_cur); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_dropped: %0d out_valid strobes after reset, expected 0", seen); end
    model_d = 50;
  endtask

  task automatic test_back_to_back();
    int dl[3] = '{33, 70, 88};
    for (int k = 0; k < 3; k++) begin
      set_manual(dl[k]);
      for (int n = 0; n < 6; n++) send(rand88(), rand88());
      idle();
    end
    send(-p42, p42);
    idle();
  endtask

  initial begin
    p40 = 88'sh100_0000_0000;
    p42 = 88'sh400_0000_0000;
    test_reset();
    test_manual();
    test_saturation();
    test_clamp();
    test_auto();
    test_auto_exit();
    test_reset_midflight();
    test_back_to_back();
    for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL drain: %0d samples never produced out_valid, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
